pipif_pfq_rv32: RTL

PIPIF_PFQ_RV32 -- requirements
Module: pipif_pfq_rv32

---
 rtl/pipif_pfq_rv32.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pipif_pfq_rv32.sv
// RV32 instruction prefetch queue: credit-limited ICache fetch, in-order response queue, branch flush.
// Optional macro PIPIF_PERF_COUNTERS_EN adds consume/branch performance counters.
module pipif_pfq_rv32 #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH  = 4
) (
  input  logic        iCLK,
  input  logic        iRSTn,
  output logic        oIREQ,
  output logic [31:0] oIADDR,
  input  logic        iIGNT,
  input  logic        iIRVALID,
  input  logic [31:0] iIRDATA,
  input  logic        iBRANCH,
  input  logic [31:0] iBranchADDR,
  input  logic        iSTALL,
  output logic        oINSTR_VALID,
  output logic [31:0] oINSTR,
  output logic [31:0] oINSTR_PC
`ifdef PIPIF_PERF_COUNTERS_EN
  ,
  output logic [31:0] oFETCH_CNT,
  output logic [15:0] oFLUSH_CNT
`endif
);

  localparam int unsigned PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0]   LP_DEPTH = (CW + 1)'(FQ_DEPTH);
  localparam logic [PW-1:0] P_ONE    = PW'(1);
  localparam logic [CW-1:0] C_ONE    = CW'(1);

  logic [31:0]   r_pc;
  logic [31:0]   r_rpc;       // address of the next non-discarded response
  logic [31:0]   r_q_instr [FQ_DEPTH];
  logic [31:0]   r_q_pc    [FQ_DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_out;       // all outstanding responses, stale ones included
  logic [CW-1:0] r_disc;
  logic          r_run;

  logic          w_xfer, w_push, w_pop;
  logic [CW:0]   w_used;
  logic [CW-1:0] w_out_nxt;
  logic [31:0]   w_target;
  logic          w_unused_addr;

  assign w_unused_addr = ^iBranchADDR[1:0];
  assign w_target      = {iBranchADDR[31:2], 2'b00};

  always_comb begin
    w_used    = {1'b0, r_cnt} + {1'b0, r_out};
    oIREQ     = r_run && (w_used < LP_DEPTH) && !iBRANCH;
    w_xfer    = oIREQ && iIGNT;
    w_push    = iIRVALID && (r_disc == '0) && !iBRANCH;
    w_pop     = (r_cnt != '0) && !iSTALL && !iBRANCH;
    w_out_nxt = r_out + {{(CW-1){1'b0}}, w_xfer} - {{(CW-1){1'b0}}, iIRVALID};
  end

  assign oIADDR       = r_pc;
  assign oINSTR_VALID = (r_cnt != '0);
  assign oINSTR       = oINSTR_VALID ? r_q_instr[r_rp] : '0;
  assign oINSTR_PC    = oINSTR_VALID ? r_q_pc[r_rp]    : '0;

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      r_pc   <= RESET_VEC;
      r_rpc  <= RESET_VEC;
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_out  <= '0;
      r_disc <= '0;
      r_run  <= 1'b0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        r_q_instr[i] <= '0;
        r_q_pc[i]    <= '0;
      end
    end else begin
      r_run <= 1'b1;
      r_out <= w_out_nxt;
      if (iBRANCH) begin
        // Every response still outstanding after this edge belongs to the old path.
        r_pc   <= w_target;
        r_rpc  <= w_target;
        r_wp   <= '0;
        r_rp   <= '0;
        r_cnt  <= '0;
        r_disc <= w_out_nxt;
      end else begin
        if (w_xfer) r_pc <= r_pc + 32'd4;
        if (iIRVALID && (r_disc != '0)) r_disc <= r_disc - C_ONE;
        if (w_push) begin
          r_q_instr[r_wp] <= iIRDATA;
          r_q_pc[r_wp]    <= r_rpc;
          r_wp            <= r_wp + P_ONE;
          r_rpc           <= r_rpc + 32'd4;
        end
        if (w_pop) r_rp <= r_rp + P_ONE;
        if (w_push && !w_pop)      r_cnt <= r_cnt + C_ONE;
        else if (!w_push && w_pop) r_cnt <= r_cnt - C_ONE;
      end
    end
  end

`ifdef PIPIF_PERF_COUNTERS_EN
  logic [31:0] r_fetch_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      r_fetch_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_pop)   r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (iBRANCH) r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign oFETCH_CNT = r_fetch_cnt;
  assign oFLUSH_CNT = r_flush_cnt;
`endif

endmodule
